enigma_rotor_engine: RTL

//  Clocked, parametrised rotor cipher engine: streams 8-bit ASCII characters, encrypting each capital letter

---
 rtl/enigma_rotor_engine.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/enigma_rotor_engine.sv
// Streaming rotor cipher: capital letters pass through NUM_ROTORS stepping affine rotors, a fixed
// XOR-1 reflector and back; other characters are echoed. Optional plugboard: ENIGMA_PLUGBOARD_EN.
module enigma_rotor_engine #(
  parameter int NUM_ROTORS = 3,
  parameter int CHAR_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHAR_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHAR_W-1:0]       out_data,
  input  logic                    load_en,
  input  logic [5*NUM_ROTORS-1:0] load_pos,
`ifdef ENIGMA_PLUGBOARD_EN
  input  logic [9:0]              load_plug,
`endif
  output logic [5*NUM_ROTORS-1:0] rotor_pos
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_REFL,
    S_BWD,
    S_DONE
`ifdef ENIGMA_PLUGBOARD_EN
    , S_PLUG_IN
    , S_PLUG_OUT
`endif
  } state_t;

  localparam int ROT_M [4] = '{3, 5, 7, 11};
  localparam int ROT_A [4] = '{1, 7, 12, 20};
  localparam int ROT_I [4] = '{9, 21, 15, 19};
  localparam logic [1:0] LAST_IDX = 2'(NUM_ROTORS - 1);

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  // Operands are always 0..25, so a+26-b stays within six bits.
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + 6'd26 - {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] affine26(input logic [4:0] y, input int m, input int a);
    int t;
    t = m * int'(y) + a;
    return 5'(t % 26);
  endfunction

  function automatic logic [4:0] fold26(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [4:0]        x_q, x_d;
  logic [4:0]        pos_q [NUM_ROTORS];
  logic [4:0]        pos_d [NUM_ROTORS];
  logic [4:0]        step_pos [NUM_ROTORS];
  logic              out_valid_q, out_valid_d;
  logic [CHAR_W-1:0] out_data_q, out_data_d;
  logic              rdy_en_q, rdy_en_d;
  logic [4:0]        fwd_x [NUM_ROTORS];
  logic [4:0]        bwd_x [NUM_ROTORS];
  logic [4:0]        fwd_sel, bwd_sel;
  logic              is_letter;
  logic [4:0]        in_idx;
  logic              accept;
`ifdef ENIGMA_PLUGBOARD_EN
  logic [4:0]        plug_a_q, plug_a_d;
  logic [4:0]        plug_b_q, plug_b_d;

  function automatic logic [4:0] plug_swap(input logic [4:0] v, input logic [4:0] a,
                                           input logic [4:0] b);
    if (v == a) return b;
    if (v == b) return a;
    return v;
  endfunction
`endif

  // Both directions share y = (x + p) mod 26; only the wiring differs.
  for (genvar gi = 0; gi < NUM_ROTORS; gi++) begin : g_rotor
    logic [4:0] y;
    assign y          = add26(x_q, pos_q[gi]);
    assign fwd_x[gi]  = sub26(affine26(y, ROT_M[gi], ROT_A[gi]), pos_q[gi]);
    assign bwd_x[gi]  = sub26(affine26(sub26(y, 5'(ROT_A[gi])), ROT_I[gi], 0), pos_q[gi]);
    assign rotor_pos[5*gi +: 5] = pos_q[gi];
  end

  always_comb begin
    fwd_sel = fwd_x[0];
    bwd_sel = bwd_x[0];
    for (int k = 0; k < NUM_ROTORS; k++) begin
      if (idx_q == 2'(k)) begin
        fwd_sel = fwd_x[k];
        bwd_sel = bwd_x[k];
      end
    end
  end

  // Odometer stepping: each rotor advances only when its lower neighbour wraps.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      step_pos[k] = pos_q[k];
      if (carry) begin
        if (pos_q[k] == 5'd25) begin
          step_pos[k] = 5'd0;
        end else begin
          step_pos[k] = pos_q[k] + 5'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  assign is_letter = (in_data >= CHAR_W'(8'h41)) && (in_data <= CHAR_W'(8'h5A));
  assign in_idx    = 5'(in_data - CHAR_W'(8'h41));
  assign in_ready  = rdy_en_q && (state_q == S_IDLE) && !load_en;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rdy_en_d    = 1'b1;
`ifdef ENIGMA_PLUGBOARD_EN
    plug_a_d    = plug_a_q;
    plug_b_d    = plug_b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          for (int k = 0; k < NUM_ROTORS; k++) pos_d[k] = fold26(load_pos[5*k +: 5]);
`ifdef ENIGMA_PLUGBOARD_EN
          plug_a_d = fold26(load_plug[4:0]);
          plug_b_d = fold26(load_plug[9:5]);
`endif
        end else if (accept) begin
          if (is_letter) begin
            pos_d = step_pos;
            x_d   = in_idx;
            idx_d = 2'd0;
`ifdef ENIGMA_PLUGBOARD_EN
            state_d = S_PLUG_IN;
`else
            state_d = S_FWD;
`endif
          end else begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
`ifdef ENIGMA_PLUGBOARD_EN
      S_PLUG_IN: begin
        x_d     = plug_swap(x_q, plug_a_q, plug_b_q);
        state_d = S_FWD;
      end
`endif
      S_FWD: begin
        x_d = fwd_sel;
        if (idx_q == LAST_IDX) state_d = S_REFL;
        else                   idx_d   = idx_q + 2'd1;
      end
      S_REFL: begin
        x_d     = x_q ^ 5'd1;
        idx_d   = LAST_IDX;
        state_d = S_BWD;
      end
      S_BWD: begin
        x_d = bwd_sel;
        if (idx_q == 2'd0) begin
`ifdef ENIGMA_PLUGBOARD_EN
          state_d = S_PLUG_OUT;
`else
          out_data_d  = CHAR_W'(bwd_sel) + CHAR_W'(8'h41);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
`endif
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
`ifdef ENIGMA_PLUGBOARD_EN
      S_PLUG_OUT: begin
        x_d         = plug_swap(x_q, plug_a_q, plug_b_q);
        out_data_d  = CHAR_W'(plug_swap(x_q, plug_a_q, plug_b_q)) + CHAR_W'(8'h41);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      x_q         <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rdy_en_q    <= 1'b0;
      for (int k = 0; k < NUM_ROTORS; k++) pos_q[k] <= 5'd0;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_a_q    <= 5'd0;
      plug_b_q    <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rdy_en_q    <= rdy_en_d;
      pos_q       <= pos_d;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_a_q    <= plug_a_d;
      plug_b_q    <= plug_b_d;
`endif
    end
  end

endmodule
